// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared thread-id, scheduler state and timing constants for the stack processor
package processor_pkg;
  localparam int NTHREADS_DEF  = 2;
  localparam int TIDW_DEF      = $clog2(NTHREADS_DEF);
  localparam int BARREL_DEPTH  = NTHREADS_DEF;
  localparam int STALL_CYC_DEF = 2;
  localparam int DRAIN_CYC_DEF = 4;
  localparam int STALL_W       = 3;

  typedef logic [TIDW_DEF-1:0] tid_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority picker: first set bit of elig scanning rr+1, rr+2, ... modulo NTHREADS
module rr_pick #(
  parameter int NTHREADS = 2,
  parameter int TIDW     = 1
) (
  input  logic [NTHREADS-1:0] elig,
  input  logic [TIDW-1:0]     rr,
  output logic                found,
  output logic [TIDW-1:0]     index
);
  logic [TIDW-1:0] cand;

  // Scan farthest-first so the nearest candidate after rr overwrites the others.
  always_comb begin
    found = 1'b0;
    index = rr;
    cand  = '0;
    for (int k = NTHREADS; k >= 1; k--) begin
      cand = rr + TIDW'(k);
      if (elig[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end
endmodule

// File: rtl/thread_issue_scheduler.sv
// rtl/thread_issue_scheduler.sv - per-cycle fetch thread selector; STRICT_ALTERNATE_EN selects barrel time-slicing
module thread_issue_scheduler
  import processor_pkg::*;
#(
  parameter int NTHREADS  = NTHREADS_DEF,
  parameter int TIDW      = TIDW_DEF,
  parameter int STALL_CYC = STALL_CYC_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NTHREADS-1:0] halt_set,
  input  logic                redirect_valid,
  input  logic [TIDW-1:0]     redirect_tid,
  output logic                issue_valid,
  output logic [TIDW-1:0]     issue_tid,
  output logic [NTHREADS-1:0] halted,
  output logic                done
);
  sched_state_t        state;
  logic [STALL_W-1:0]  stall_cnt [NTHREADS];
  logic [7:0]          drain_cnt;
  logic [NTHREADS-1:0] elig;
  logic [NTHREADS-1:0] halt_acc;
  logic                all_halt;

  always_comb begin
    elig = '0;
    for (int t = 0; t < NTHREADS; t++)
      elig[t] = (state == RUN) && !halted[t] && (stall_cnt[t] == '0);
  end

  // Halts arriving after completion are irrelevant; everything is already halted.
  assign halt_acc = (state == DONE) ? '0 : halt_set;
  assign all_halt = &(halted | halt_acc);

`ifdef STRICT_ALTERNATE_EN
  logic [TIDW-1:0] slot;
`else
  logic [TIDW-1:0] rr;
  logic            pick_found;
  logic [TIDW-1:0] pick_index;

  rr_pick #(.NTHREADS(NTHREADS), .TIDW(TIDW)) u_pick (
    .elig  (elig),
    .rr    (rr),
    .found (pick_found),
    .index (pick_index)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      issue_valid <= 1'b0;
      issue_tid   <= '0;
      halted      <= '0;
      done        <= 1'b0;
      drain_cnt   <= '0;
      for (int t = 0; t < NTHREADS; t++) stall_cnt[t] <= '0;
`ifdef STRICT_ALTERNATE_EN
      slot        <= '0;
`else
      rr          <= TIDW'(NTHREADS - 1);
`endif
    end else begin
      halted <= halted | halt_acc;
      // Halt beats a same-cycle redirect; a redirect reloads rather than accumulates.
      for (int t = 0; t < NTHREADS; t++) begin
        if (halt_acc[t])
          stall_cnt[t] <= '0;
        else if (redirect_valid && redirect_tid == TIDW'(t) && !halted[t])
          stall_cnt[t] <= STALL_W'(STALL_CYC);
        else if (stall_cnt[t] != '0)
          stall_cnt[t] <= stall_cnt[t] - 1'b1;
      end

      case (state)
        IDLE: begin
          issue_valid <= 1'b0;
          if (start) state <= RUN;
        end
        RUN: begin
`ifdef STRICT_ALTERNATE_EN
          issue_valid <= elig[slot];
          issue_tid   <= slot;
          slot        <= slot + 1'b1;
`else
          issue_valid <= pick_found;
          if (pick_found) begin
            issue_tid <= pick_index;
            rr        <= pick_index;
          end
`endif
          if (all_halt) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          issue_valid <= 1'b0;
          if (drain_cnt == 8'(DRAIN_CYC - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          issue_valid <= 1'b0;
          done        <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_thread_issue_scheduler.sv
// tb/tb_thread_issue_scheduler.sv - scoreboard bench for thread_issue_scheduler (default build, NTHREADS=2)
module tb_thread_issue_scheduler;
  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] halt_set;
  logic       redirect_valid;
  logic       redirect_tid;
  logic       issue_valid;
  logic       issue_tid;
  logic [1:0] halted;
  logic       done;

  typedef struct {
    int         idx;
    logic       v;
    logic       tid;
    logic       chk_tid;
    logic [1:0] h;
    logic       d;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_step = 0;

  thread_issue_scheduler #(
    .NTHREADS(2), .TIDW(1), .STALL_CYC(2), .DRAIN_CYC(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .halt_set       (halt_set),
    .redirect_valid (redirect_valid),
    .redirect_tid   (redirect_tid),
    .issue_valid    (issue_valid),
    .issue_tid      (issue_tid),
    .halted         (halted),
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, req);
    end
  endtask

  // Monitor: outputs after each active edge belong to the vector applied before it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("issue_valid", e.idx, {1'b0, issue_valid}, {1'b0, e.v});
        if (e.chk_tid) check("issue_tid", e.idx, {1'b0, issue_tid}, {1'b0, e.tid});
        check("halted", e.idx, halted, e.h);
        check("done", e.idx, {1'b0, done}, {1'b0, e.d});
      end
    end
  end

  task automatic step(input logic rst, input logic st, input logic [1:0] hs,
                      input logic rv, input logic rt,
                      input logic ev, input logic et, input logic [1:0] eh, input logic ed);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    start          = st;
    halt_set       = hs;
    redirect_valid = rv;
    redirect_tid   = rt;
    e.idx     = n_step;
    e.v       = ev;
    e.tid     = et;
    e.chk_tid = ev | rst;
    e.h       = eh;
    e.d       = ed;
    exp_q.push_back(e);
    n_step++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_set = 2'b00; redirect_valid = 1'b0; redirect_tid = 1'b0;
    //   rst st  hs    rv rt   v  tid halted done
    step(1, 0, 2'b00, 0, 0,   0, 0, 2'b00, 0);
    step(1, 0, 2'b00, 0, 0,   0, 0, 2'b00, 0);
    step(0, 1, 2'b00, 0, 0,   0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 1, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 0, 2'b00, 0);
    // redirect thread 1: two slots to thread 0, then thread 1 resumes
    step(0, 0, 2'b00, 1, 1,   1, 1, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 1, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 1, 2'b00, 0);
    // back-to-back redirects of both threads: one bubble, thread 0 first
    step(0, 0, 2'b00, 1, 0,   1, 0, 2'b00, 0);
    step(0, 0, 2'b00, 1, 1,   1, 1, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 1, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 0, 2'b00, 0);
    // halt and redirect of thread 1 together; thread 1 never issues again
    step(0, 0, 2'b10, 1, 1,   1, 1, 2'b10, 0);
    step(0, 0, 2'b00, 0, 0,   1, 0, 2'b10, 0);
    step(0, 0, 2'b00, 1, 1,   1, 0, 2'b10, 0);
    step(0, 0, 2'b00, 0, 0,   1, 0, 2'b10, 0);
    // last halt: drain 4 cycles then done
    step(0, 0, 2'b01, 0, 0,   1, 0, 2'b11, 0);
    step(0, 0, 2'b00, 0, 0,   0, 0, 2'b11, 0);
    step(0, 0, 2'b00, 0, 0,   0, 0, 2'b11, 0);
    step(0, 0, 2'b00, 0, 0,   0, 0, 2'b11, 0);
    step(0, 0, 2'b00, 0, 0,   0, 0, 2'b11, 1);
    step(0, 0, 2'b00, 0, 0,   0, 0, 2'b11, 1);
    step(0, 1, 2'b11, 0, 0,   0, 0, 2'b11, 1);
    // reset from DONE and restart
    step(1, 0, 2'b00, 0, 0,   0, 0, 2'b00, 0);
    step(0, 1, 2'b00, 0, 0,   0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 1, 2'b00, 0);
    // halt both at once, reset mid-DRAIN, restart at thread 0
    step(0, 0, 2'b11, 0, 0,   1, 0, 2'b11, 0);
    step(0, 0, 2'b00, 0, 0,   0, 0, 2'b11, 0);
    step(1, 0, 2'b00, 0, 0,   0, 0, 2'b00, 0);
    step(0, 1, 2'b00, 0, 0,   0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 1, 2'b00, 0);
    // repeated redirect reloads the stall counter instead of accumulating
    step(0, 0, 2'b00, 1, 0,   1, 0, 2'b00, 0);
    step(0, 0, 2'b00, 1, 0,   1, 1, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 1, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 1, 2'b00, 0);
    step(0, 0, 2'b00, 0, 0,   1, 0, 2'b00, 0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; halt_set = 2'b00; redirect_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
